adpll_loop_controller: RTL and testbench
========================================

Name: adpll_loop_controller

Overview:
Digital loop-filter and lock controller for the ADPLL, sitting between the phase detector (signed clock-cycle phase error per reference period) and the DCO tuning input. Runs a proportional-integral filter whose gains change with loop state. Sequences the loop through idle, acquisition, tracking and holdover. Reports lock status to the rest of the design.

Parameters:
ERR_W, 8, width of signed phase-error input (clock cycles)
TUNE_W, 12, width of unsigned DCO tuning word
TUNE_INIT, 2048, tuning word in reset/IDLE (mid-scale)
KP_SHL_ACQ, 4, proportional left-shift in ACQUIRE
KI_SHL_ACQ, 2, integral left-shift in ACQUIRE
KP_SHL_TRK, 2, proportional left-shift in TRACK
KI_SHL_TRK, 0, integral left-shift in TRACK
LOCK_TOL, 1, |err| at or below this counts toward lock
UNLOCK_TOL, 4, |err| above this counts toward unlock
LOCK_COUNT, 8, consecutive in-tolerance samples to declare lock
UNLOCK_COUNT, 4, consecutive out-of-tolerance samples to drop lock
TIMEOUT, 1024, fpga_clk cycles without pd_valid_i before HOLDOVER

Ports:
fpga_clk_i  in  1  single system clock, all logic rising-edge
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  loop enable; low forces IDLE
pd_valid_i  in  1  one-cycle strobe, new phase-error sample
pd_error_i  in  ERR_W  signed phase error (positive = generated lags reference)
dco_tune_o  out  TUNE_W  DCO tuning word
tune_valid_o  out  1  one-cycle strobe, dco_tune_o updated
locked_o  out  1  high while in TRACK
state_o  out  2  current state encoding

Behaviour:
- Reset (async assert, sync release): dco_tune_o=TUNE_INIT, tune_valid_o=0, locked_o=0, state_o=IDLE, integrator=0, all counters=0.
- States: IDLE=0, ACQUIRE=1, TRACK=2, HOLDOVER=3.
- IDLE->ACQUIRE on the cycle after enable_i is seen high.
- ACQUIRE->TRACK when LOCK_COUNT consecutive accepted samples have |err|<=LOCK_TOL. Any sample outside tolerance clears the count.
- TRACK->ACQUIRE when UNLOCK_COUNT consecutive samples have |err|>UNLOCK_TOL. Any sample at or below UNLOCK_TOL clears the count.
- ACQUIRE/TRACK->HOLDOVER when the idle-cycle counter reaches TIMEOUT. The counter clears on every pd_valid_i.
- HOLDOVER: dco_tune_o and integrator frozen, locked_o=0. The next pd_valid_i moves the block to ACQUIRE. That sample is discarded: no tune update, lock counters cleared.
- enable_i low in any state: IDLE next cycle, integrator cleared, dco_tune_o=TUNE_INIT, counters cleared, in-flight pipeline update squashed (no tune_valid_o). If enable_i is low in the same cycle as pd_valid_i, the sample is dropped.
- Abs value for tolerance compares: -2^(ERR_W-1) maps to 2^(ERR_W-1)-1.
- Pipeline (samples accepted in ACQUIRE/TRACK, back-to-back every cycle supported):
  - Stage 1 (cycle after pd_valid_i): integ <= clamp(integ + (err<<<KI), -2^(TUNE_W-1), 2^(TUNE_W-1)-1); p <= err<<<KP. State and lock counters update in this cycle.
  - Stage 2: dco_tune_o <= clamp(TUNE_INIT + integ + p, 0, 2^TUNE_W-1), with tune_valid_o=1.
  - Latency: pd_valid_i to tune_valid_o is exactly 2 cycles.
- Gain selection: each sample uses the state it was accepted in. A sample that triggers ACQUIRE->TRACK is still filtered with ACQUIRE gains.
- Internal sums use TUNE_W+4 signed bits so there is no overflow before clamping.
- locked_o is registered equal to (state==TRACK).

Decomposition:
- Package adpll_pkg: state enum type (2-bit), state encodings, default gain/tolerance constants shared with the DCO and the phase detector bench.
- Sub-module adpll_lock_detect: consecutive-sample lock/unlock counters with tolerance compares. Outputs lock_hit and unlock_hit pulses to the FSM.

Test Plan:
- Reset, then enable_i=1, then one sample err=+4 in ACQUIRE -> 2 cycles later tune_valid_o=1, dco_tune_o=2048+16+64=2128. Second +4 -> 2144.
- 8 samples err=0 after enable -> state_o=TRACK and locked_o=1 one cycle after the 8th pd_valid_i. Next err=+4 -> tune uses TRACK gains: integ+4, p=16.
- In TRACK, 4 consecutive err=+5 -> ACQUIRE, locked_o=0. Sequence +5,+5,+3,+5 -> stays in TRACK.
- Repeated err=+127 in ACQUIRE -> dco_tune_o clamps at 4095 and integrator at 2047. Repeated err=-128 -> dco_tune_o clamps at 0.
- No pd_valid_i for 1024 cycles in TRACK -> HOLDOVER, dco_tune_o frozen. Next sample -> ACQUIRE with no tune_valid_o for that sample.
- enable_i low in the cycle after pd_valid_i -> no tune_valid_o, dco_tune_o=2048, IDLE. Async reset_n_i low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared ADPLL loop types and default gain/tolerance constants, used by the
// loop controller, the DCO and the phase-detector bench.
package adpll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_TRACK    = 2'd2,
    ST_HOLDOVER = 2'd3
  } adpll_state_t;

  localparam int ADPLL_ERR_W        = 8;
  localparam int ADPLL_TUNE_W       = 12;
  localparam int ADPLL_TUNE_INIT    = 2048;
  localparam int ADPLL_KP_SHL_ACQ   = 4;
  localparam int ADPLL_KI_SHL_ACQ   = 2;
  localparam int ADPLL_KP_SHL_TRK   = 2;
  localparam int ADPLL_KI_SHL_TRK   = 0;
  localparam int ADPLL_LOCK_TOL     = 1;
  localparam int ADPLL_UNLOCK_TOL   = 4;
  localparam int ADPLL_LOCK_COUNT   = 8;
  localparam int ADPLL_UNLOCK_COUNT = 4;
  localparam int ADPLL_TIMEOUT      = 1024;

endpackage

// File: rtl/adpll_lock_detect.sv
// Consecutive-sample lock/unlock qualification; hit pulses are combinational
// so the FSM changes state on the same edge that accepts the deciding sample.
module adpll_lock_detect
  import adpll_pkg::*;
#(
  parameter int ERR_W        = ADPLL_ERR_W,
  parameter int LOCK_TOL     = ADPLL_LOCK_TOL,
  parameter int UNLOCK_TOL   = ADPLL_UNLOCK_TOL,
  parameter int LOCK_COUNT   = ADPLL_LOCK_COUNT,
  parameter int UNLOCK_COUNT = ADPLL_UNLOCK_COUNT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    acq_sample,
  input  logic                    trk_sample,
  input  logic signed [ERR_W-1:0] err,
  output logic                    lock_hit,
  output logic                    unlock_hit
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int UCW = $clog2(UNLOCK_COUNT + 1);
  localparam logic signed [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};

  logic [ERR_W-1:0] abs_err;
  logic             in_lock_tol;
  logic             out_unlock_tol;
  logic [LCW-1:0]   lock_cnt;
  logic [UCW-1:0]   unlock_cnt;

  // Most-negative error saturates to the largest positive magnitude.
  always_comb begin
    if (err == ERR_MIN) begin
      abs_err = {1'b0, {(ERR_W-1){1'b1}}};
    end else if (err < 0) begin
      abs_err = $unsigned(-err);
    end else begin
      abs_err = $unsigned(err);
    end
    in_lock_tol    = abs_err <= ERR_W'(LOCK_TOL);
    out_unlock_tol = abs_err > ERR_W'(UNLOCK_TOL);
    lock_hit       = acq_sample && in_lock_tol && (lock_cnt == LCW'(LOCK_COUNT - 1));
    unlock_hit     = trk_sample && out_unlock_tol && (unlock_cnt == UCW'(UNLOCK_COUNT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else if (clear || lock_hit || unlock_hit) begin
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else begin
      if (acq_sample) lock_cnt <= in_lock_tol ? lock_cnt + 1'b1 : '0;
      if (trk_sample) unlock_cnt <= out_unlock_tol ? unlock_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/adpll_loop_controller.sv
// ADPLL PI loop filter and lock sequencer: two-stage filter pipeline feeding the
// DCO tuning word, with idle/acquire/track/holdover control.
module adpll_loop_controller
  import adpll_pkg::*;
#(
  parameter int ERR_W        = ADPLL_ERR_W,
  parameter int TUNE_W       = ADPLL_TUNE_W,
  parameter int TUNE_INIT    = ADPLL_TUNE_INIT,
  parameter int KP_SHL_ACQ   = ADPLL_KP_SHL_ACQ,
  parameter int KI_SHL_ACQ   = ADPLL_KI_SHL_ACQ,
  parameter int KP_SHL_TRK   = ADPLL_KP_SHL_TRK,
  parameter int KI_SHL_TRK   = ADPLL_KI_SHL_TRK,
  parameter int LOCK_TOL     = ADPLL_LOCK_TOL,
  parameter int UNLOCK_TOL   = ADPLL_UNLOCK_TOL,
  parameter int LOCK_COUNT   = ADPLL_LOCK_COUNT,
  parameter int UNLOCK_COUNT = ADPLL_UNLOCK_COUNT,
  parameter int TIMEOUT      = ADPLL_TIMEOUT
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    pd_valid_i,
  input  logic signed [ERR_W-1:0] pd_error_i,
  output logic [TUNE_W-1:0]       dco_tune_o,
  output logic                    tune_valid_o,
  output logic                    locked_o,
  output logic [1:0]              state_o
);

  localparam int SW  = TUNE_W + 4;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic signed [SW-1:0] INTEG_MAX = SW'((1 << (TUNE_W - 1)) - 1);
  localparam logic signed [SW-1:0] INTEG_MIN = SW'(-(1 << (TUNE_W - 1)));
  localparam logic signed [SW-1:0] TUNE_MAX  = SW'((1 << TUNE_W) - 1);
  localparam logic signed [SW-1:0] TUNE_BASE = SW'(TUNE_INIT);

  adpll_state_t             state;
  logic signed [TUNE_W-1:0] integ;
  logic signed [SW-1:0]     p_term;
  logic                     s1_valid;
  logic [TCW-1:0]           idle_cnt;

  logic                     active, in_acq, accept, timeout;
  logic                     lock_hit, unlock_hit, ld_clear;
  logic signed [SW-1:0]     err_ext, integ_sum, p_next, tune_sum;
  logic signed [TUNE_W-1:0] integ_next;
  logic [TUNE_W-1:0]        tune_next;

  always_comb begin
    active   = (state == ST_ACQUIRE) || (state == ST_TRACK);
    in_acq   = (state == ST_ACQUIRE);
    accept   = enable_i && pd_valid_i && active;
    timeout  = active && !pd_valid_i && (idle_cnt == TCW'(TIMEOUT - 1));
    ld_clear = !enable_i || !active || timeout;

    // Gains follow the state the sample arrives in, even if it triggers a change.
    err_ext   = SW'(pd_error_i);
    integ_sum = SW'(integ) + (in_acq ? (err_ext <<< KI_SHL_ACQ) : (err_ext <<< KI_SHL_TRK));
    p_next    = in_acq ? (err_ext <<< KP_SHL_ACQ) : (err_ext <<< KP_SHL_TRK);
    if (integ_sum > INTEG_MAX)      integ_next = TUNE_W'(INTEG_MAX);
    else if (integ_sum < INTEG_MIN) integ_next = TUNE_W'(INTEG_MIN);
    else                            integ_next = TUNE_W'(integ_sum);

    tune_sum = TUNE_BASE + SW'(integ) + p_term;
    if (tune_sum < 0)             tune_next = '0;
    else if (tune_sum > TUNE_MAX) tune_next = '1;
    else                          tune_next = TUNE_W'(tune_sum);
  end

  adpll_lock_detect #(
    .ERR_W       (ERR_W),
    .LOCK_TOL    (LOCK_TOL),
    .UNLOCK_TOL  (UNLOCK_TOL),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_lock_detect (
    .clk       (fpga_clk_i),
    .rst_n     (reset_n_i),
    .clear     (ld_clear),
    .acq_sample(accept && in_acq),
    .trk_sample(accept && !in_acq),
    .err       (pd_error_i),
    .lock_hit  (lock_hit),
    .unlock_hit(unlock_hit)
  );

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      locked_o     <= 1'b0;
      dco_tune_o   <= TUNE_W'(TUNE_INIT);
      tune_valid_o <= 1'b0;
      s1_valid     <= 1'b0;
      integ        <= '0;
      p_term       <= '0;
      idle_cnt     <= '0;
    end else if (!enable_i) begin
      // Disable squashes any in-flight stage-1 result as well.
      state        <= ST_IDLE;
      locked_o     <= 1'b0;
      dco_tune_o   <= TUNE_W'(TUNE_INIT);
      tune_valid_o <= 1'b0;
      s1_valid     <= 1'b0;
      integ        <= '0;
      p_term       <= '0;
      idle_cnt     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        integ  <= integ_next;
        p_term <= p_next;
      end
      tune_valid_o <= s1_valid;
      if (s1_valid) dco_tune_o <= tune_next;
      idle_cnt <= (!active || pd_valid_i || timeout) ? '0 : idle_cnt + 1'b1;

      case (state)
        ST_IDLE: state <= ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (timeout) begin
            state <= ST_HOLDOVER;
          end else if (lock_hit) begin
            state    <= ST_TRACK;
            locked_o <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (timeout) begin
            state    <= ST_HOLDOVER;
            locked_o <= 1'b0;
          end else if (unlock_hit) begin
            state    <= ST_ACQUIRE;
            locked_o <= 1'b0;
          end
        end
        ST_HOLDOVER: if (pd_valid_i) state <= ST_ACQUIRE;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_adpll_loop_controller.sv
// Self-checking bench for adpll_loop_controller: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_adpll_loop_controller;

  localparam int ERR_W = 8;
  localparam int TUNE_W = 12;
  localparam int T_INIT = 2048;
  localparam int KP_ACQ = 16;   // 1 << 4
  localparam int KI_ACQ = 4;    // 1 << 2
  localparam int KP_TRK = 4;    // 1 << 2
  localparam int KI_TRK = 1;    // 1 << 0
  localparam int L_TOL = 1;
  localparam int U_TOL = 4;
  localparam int L_CNT = 8;
  localparam int U_CNT = 4;
  localparam int T_OUT = 1024;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enable;
  logic                    pd_valid;
  logic signed [ERR_W-1:0] pd_err;
  logic [TUNE_W-1:0]       dco_tune;
  logic                    tune_valid;
  logic                    locked;
  logic [1:0]              state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adpll_loop_controller #(
    .ERR_W (ERR_W),
    .TUNE_W(TUNE_W)
  ) dut (
    .fpga_clk_i  (clk),
    .reset_n_i   (rst_n),
    .enable_i    (enable),
    .pd_valid_i  (pd_valid),
    .pd_error_i  (pd_err),
    .dco_tune_o  (dco_tune),
    .tune_valid_o(tune_valid),
    .locked_o    (locked),
    .state_o     (state)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int cyc;
    int val;
  } pend_t;

  int    m_state, m_integ, m_tune, m_lock_run, m_unlock_run, m_idle, m_cyc;
  bit    m_tv;
  pend_t m_q[$];

  function automatic int sat(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int mag(input int e);
    return (e == -128) ? 127 : ((e < 0) ? -e : e);
  endfunction

  task automatic model_reset();
    m_state = 0; m_integ = 0; m_tune = T_INIT; m_tv = 1'b0;
    m_lock_run = 0; m_unlock_run = 0; m_idle = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit en, input bit v, input int e);
    int ki, kp;
    m_cyc++;
    m_tv = 1'b0;
    if (!en) begin
      model_reset();
      return;
    end
    if (m_q.size() > 0 && m_q[0].cyc == m_cyc) begin
      m_tune = m_q[0].val;
      m_tv = 1'b1;
      void'(m_q.pop_front());
    end
    case (m_state)
      0: m_state = 1;
      1, 2: begin
        if (v) begin
          ki = (m_state == 1) ? KI_ACQ : KI_TRK;
          kp = (m_state == 1) ? KP_ACQ : KP_TRK;
          m_idle = 0;
          m_integ = sat(m_integ + e * ki, -2048, 2047);
          m_q.push_back('{cyc: m_cyc + 1, val: sat(T_INIT + m_integ + e * kp, 0, 4095)});
          if (m_state == 1) begin
            m_lock_run = (mag(e) <= L_TOL) ? m_lock_run + 1 : 0;
            if (m_lock_run == L_CNT) begin m_state = 2; m_lock_run = 0; end
          end else begin
            m_unlock_run = (mag(e) > U_TOL) ? m_unlock_run + 1 : 0;
            if (m_unlock_run == U_CNT) begin m_state = 1; m_unlock_run = 0; end
          end
        end else begin
          m_idle++;
          if (m_idle == T_OUT) begin
            m_state = 3; m_idle = 0; m_lock_run = 0; m_unlock_run = 0;
          end
        end
      end
      default: if (v) m_state = 1;
    endcase
  endtask

  task automatic step(input bit en, input bit v, input int e);
    enable = en;
    pd_valid = v;
    pd_err = 8'(e);
    @(posedge clk);
    model_edge(en, v, e);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pd_valid = 1'b0; pd_err = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (dco_tune !== 12'd2048) begin errors++; $display("FAIL reset_tune got=%0d exp=2048", dco_tune); end
    checks++; if (tune_valid !== 1'b0) begin errors++; $display("FAIL reset_tv got=%b exp=0", tune_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    rst_n = 1'b1;
    step(0, 0, 0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold_state got=%0d exp=0", state); end
  endtask

  task automatic test_acquire();
    step(1, 0, 0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL enter_acq_state got=%0d exp=1", state); end
    step(1, 1, 4);
    checks++; if (tune_valid !== 1'b0) begin errors++; $display("FAIL acq_latency1 tv got=%b exp=0", tune_valid); end
    step(1, 1, 4);
    checks++; if (tune_valid !== 1'b1 || dco_tune !== 12'd2128) begin errors++; $display("FAIL acq_first tv=%b tune got=%0d exp=2128", tune_valid, dco_tune); end
    step(1, 0, 0);
    checks++; if (tune_valid !== 1'b1 || dco_tune !== 12'd2144) begin errors++; $display("FAIL acq_second tv=%b tune got=%0d exp=2144", tune_valid, dco_tune); end
    step(1, 0, 0);
    checks++; if (tune_valid !== 1'b0 || dco_tune !== 12'd2144) begin errors++; $display("FAIL acq_hold tv=%b tune got=%0d exp=2144", tune_valid, dco_tune); end
  endtask

  task automatic test_lock();
    int lk[8] = '{0, 1, -1, 0, -1, 1, 0, 0};
    // err=2 breaks the in-tolerance run
    step(0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    step(1, 1, 2);
    for (int i = 0; i < 7; i++) step(1, 1, 0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lock_run_reset state got=%0d exp=1", state); end
    step(1, 1, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL lock_after_restart state got=%0d exp=2", state); end

    step(0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, lk[i]);
      if (i == 6) begin
        checks++; if (state !== 2'd1 || locked !== 1'b0) begin errors++; $display("FAIL lock_early state=%0d locked=%b exp=1/0", state, locked); end
      end
    end
    checks++; if (state !== 2'd2 || locked !== 1'b1) begin errors++; $display("FAIL lock_8th state=%0d locked=%b exp=2/1", state, locked); end
    step(1, 1, 4);
    step(1, 0, 0);
    checks++; if (tune_valid !== 1'b1 || dco_tune !== 12'd2068) begin errors++; $display("FAIL track_gain tv=%b tune got=%0d exp=2068", tune_valid, dco_tune); end
  endtask

  task automatic test_unlock();
    int keep[5] = '{5, 5, 4, 5, 0};
    int drop[4] = '{5, -5, 5, -5};
    for (int i = 0; i < 5; i++) step(1, 1, keep[i]);
    checks++; if (state !== 2'd2 || locked !== 1'b1) begin errors++; $display("FAIL unlock_broken state=%0d locked=%b exp=2/1", state, locked); end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, drop[i]);
      if (i == 2) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL unlock_early state got=%0d exp=2", state); end
      end
    end
    checks++; if (state !== 2'd1 || locked !== 1'b0) begin errors++; $display("FAIL unlock_4th state=%0d locked=%b exp=1/0", state, locked); end
    step(1, 0, 0);
    step(1, 0, 0);
    checks++; if (dco_tune !== 12'(m_tune) || tune_valid !== m_tv) begin errors++; $display("FAIL unlock_tune got=%0d/%b exp=%0d/%b", dco_tune, tune_valid, m_tune, m_tv); end
  endtask

  task automatic test_clamp();
    step(0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 127);
    checks++; if (dco_tune !== 12'd4095) begin errors++; $display("FAIL clamp_high tune got=%0d exp=4095", dco_tune); end
    step(1, 1, -1);
    step(1, 0, 0);
    checks++; if (dco_tune !== 12'd4075) begin errors++; $display("FAIL integ_clamp_high tune got=%0d exp=4075", dco_tune); end
    for (int i = 0; i < 30; i++) step(1, 1, -128);
    checks++; if (dco_tune !== 12'd0) begin errors++; $display("FAIL clamp_low tune got=%0d exp=0", dco_tune); end
    step(1, 1, 1);
    step(1, 0, 0);
    checks++; if (dco_tune !== 12'd20) begin errors++; $display("FAIL integ_clamp_low tune got=%0d exp=20", dco_tune); end
  endtask

  task automatic test_timeout();
    bit seen_tv;
    step(0, 0, 0); step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 0);
    step(1, 1, 3);
    repeat (T_OUT - 1) step(1, 0, 0);
    checks++; if (state !== 2'd2 || dco_tune !== 12'd2063) begin errors++; $display("FAIL pre_timeout state=%0d tune=%0d exp=2/2063", state, dco_tune); end
    step(1, 0, 0);
    checks++; if (state !== 2'd3 || locked !== 1'b0) begin errors++; $display("FAIL timeout state=%0d locked=%b exp=3/0", state, locked); end
    seen_tv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0);
      if (tune_valid) seen_tv = 1'b1;
    end
    checks++; if (seen_tv || dco_tune !== 12'd2063) begin errors++; $display("FAIL holdover_frozen tv_seen=%b tune got=%0d exp=2063", seen_tv, dco_tune); end
    step(1, 1, 50);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL holdover_exit state got=%0d exp=1", state); end
    step(1, 0, 0); step(1, 0, 0);
    checks++; if (tune_valid !== 1'b0 || dco_tune !== 12'd2063) begin errors++; $display("FAIL holdover_discard tv=%b tune got=%0d exp=2063", tune_valid, dco_tune); end
  endtask

  task automatic test_disable();
    step(1, 0, 0);
    step(1, 1, 4);
    step(0, 0, 0);
    checks++; if (tune_valid !== 1'b0 || dco_tune !== 12'd2048 || state !== 2'd0) begin errors++; $display("FAIL disable_squash tv=%b tune=%0d state=%0d exp=0/2048/0", tune_valid, dco_tune, state); end
    step(0, 1, 9);
    step(1, 0, 0);
    step(1, 0, 0);
    checks++; if (tune_valid !== 1'b0 || dco_tune !== 12'd2048 || state !== 2'd1) begin errors++; $display("FAIL disable_drop tv=%b tune=%0d state=%0d exp=0/2048/1", tune_valid, dco_tune, state); end
    step(1, 1, 4);
    step(1, 0, 0);
    checks++; if (tune_valid !== 1'b1 || dco_tune !== 12'd2128) begin errors++; $display("FAIL disable_integ_clear tv=%b tune got=%0d exp=2128", tune_valid, dco_tune); end
  endtask

  task automatic test_async_reset();
    step(1, 1, 60);
    step(1, 1, -30);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dco_tune !== 12'd2048 || tune_valid !== 1'b0 || locked !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL async_reset tune=%0d tv=%b locked=%b state=%0d exp=2048/0/0/0", dco_tune, tune_valid, locked, state);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0);
    step(1, 0, 0);
    checks++; if (tune_valid !== 1'b0 || state !== 2'd1) begin errors++; $display("FAIL post_reset tv=%b state=%0d exp=0/1", tune_valid, state); end
  endtask

  task automatic test_random();
    bit en, v;
    int e, r;
    step(0, 0, 0);
    for (int i = 0; i < 1200; i++) begin
      en = ($urandom_range(0, 79) != 0);
      v  = ($urandom_range(0, 9) < 7);
      r  = int'($urandom_range(0, 9));
      if (((i / 150) % 2) == 0) begin
        e = (r < 9) ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(5, 8));
      end else if (r < 4) begin
        e = int'($urandom_range(0, 255)) - 128;
      end else if (r < 8) begin
        e = int'($urandom_range(0, 12)) - 6;
      end else begin
        e = (r == 8) ? -128 : 127;
      end
      step(en, v, e);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", i, state, m_state); end
      checks++; if (locked !== (m_state == 2)) begin errors++; $display("FAIL rand_locked cyc=%0d got=%b exp=%b", i, locked, m_state == 2); end
      checks++; if (tune_valid !== m_tv) begin errors++; $display("FAIL rand_tv cyc=%0d got=%b exp=%b", i, tune_valid, m_tv); end
      checks++; if (dco_tune !== 12'(m_tune)) begin errors++; $display("FAIL rand_tune cyc=%0d got=%0d exp=%0d", i, dco_tune, m_tune); end
    end
  endtask

  initial begin
    m_cyc = 0;
    test_reset();
    test_acquire();
    test_lock();
    test_unlock();
    test_clamp();
    test_timeout();
    test_disable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
